// File: rtl/wb_pkg.sv
// Shared constants, entry layout and write-data select for the writeback queue.
package wb_pkg;

  // One-hot bit positions of align_load: {lw, lb, lbu, lh, lhu, lwl, lwr}
  localparam int AL_LW  = 6;
  localparam int AL_LB  = 5;
  localparam int AL_LBU = 4;
  localparam int AL_LH  = 3;
  localparam int AL_LHU = 2;
  localparam int AL_LWL = 1;
  localparam int AL_LWR = 0;

  localparam int SRC_ALU0 = 0;
  localparam int SRC_ALU1 = 1;
  localparam int SRC_LOAD = 2;

  localparam int RF_WEN_W = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        wen;
    logic [2:0]  src;
    logic [31:0] alu_res;
    logic [31:0] rf_b;
    logic        mem_read;
    logic [6:0]  align_load;
  } wb_entry_t;

  // src is one-hot, so an AND-OR mux picks the write data.
  function automatic logic [31:0] wb_select(input logic [2:0]  src,
                                            input logic [31:0] alu,
                                            input logic [31:0] load);
    return ({32{src[SRC_ALU0] | src[SRC_ALU1]}} & alu) |
           ({32{src[SRC_LOAD]}} & load);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data aligner: byte/half extraction and lwl/lwr merges.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] mdata,
  input  logic [31:0] rf_b,
  input  logic [1:0]  addr,
  input  logic [6:0]  align_load,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = mdata[{addr, 3'b000} +: 8];
  assign w_half = addr[1] ? mdata[31:16] : mdata[15:0];

  always_comb begin
    // NOTE: default assignment first so every path drives data and no latch is inferred.
    data = mdata;
    if (align_load[AL_LW]) begin
      data = mdata;
    end else if (align_load[AL_LB]) begin
      data = {{24{w_byte[7]}}, w_byte};
    end else if (align_load[AL_LBU]) begin
      data = {24'h0, w_byte};
    end else if (align_load[AL_LH]) begin
      data = {{16{w_half[15]}}, w_half};
    end else if (align_load[AL_LHU]) begin
      data = {16'h0, w_half};
    end else if (align_load[AL_LWL]) begin
      case (addr)
        2'd0:    data = {mdata[7:0],  rf_b[23:0]};
        2'd1:    data = {mdata[15:0], rf_b[15:0]};
        2'd2:    data = {mdata[23:0], rf_b[7:0]};
        default: data = mdata;
      endcase
    end else if (align_load[AL_LWR]) begin
      case (addr)
        2'd0:    data = mdata;
        2'd1:    data = {rf_b[31:24], mdata[31:8]};
        2'd2:    data = {rf_b[31:16], mdata[31:16]};
        default: data = {rf_b[31:8],  mdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue: buffers MA results, captures load responses,
// commits one entry per cycle and forwards from any buffered entry.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NRD   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [4:0]              in_waddr,
  input  logic                    in_wen,
  input  logic [2:0]              in_src,
  input  logic [31:0]             in_alu_res,
  input  logic [31:0]             in_rf_b,
  input  logic                    in_mem_read,
  input  logic [6:0]              in_align_load,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    rf_wen,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [31:0]             debug_pc,
  output logic [RF_WEN_W-1:0]     debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_waddr,
  output logic [31:0]             debug_wb_rf_wdata,
  input  logic [5*NRD-1:0]        fwd_raddr,
  output logic [NRD-1:0]          fwd_hit,
  output logic [NRD-1:0]          fwd_pending,
  output logic [32*NRD-1:0]       fwd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        r_entry [DEPTH];
  logic [31:0]      r_mdata [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_resp_err;

  logic [PW-1:0]    w_slot [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic             w_fill_found;
  logic [PW-1:0]    w_fill;
  wb_entry_t        w_head;
  logic             w_head_valid;
  logic             w_head_bypass;
  logic             w_commit;
  logic             w_enq;
  logic [31:0]      w_commit_mdata;
  logic [31:0]      w_commit_load;
  logic [31:0]      w_commit_data;

  // Slot i is the i-th oldest entry; live when inside the occupied range.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_slot[g] = r_head + PW'(g);
    assign w_live[g] = CW'(g) < r_count;
  end

  // fill pointer: the oldest live load still waiting for its response.
  always_comb begin
    w_fill_found = 1'b0;
    w_fill       = r_tail;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_fill_found && w_live[i] && r_entry[w_slot[i]].mem_read &&
          !r_filled[w_slot[i]]) begin
        w_fill_found = 1'b1;
        w_fill       = w_slot[i];
      end
    end
  end

  assign w_head        = r_entry[r_head];
  assign w_head_valid  = r_count != '0;
  assign w_head_bypass = w_head_valid && w_head.mem_read && !r_filled[r_head] && mem_rvalid;
  assign w_commit      = w_head_valid &&
                         (!w_head.mem_read || r_filled[r_head] || w_head_bypass);
  assign in_ready      = (r_count < CW'(DEPTH)) || w_commit;
  assign w_enq         = in_valid && in_ready;

  assign w_commit_mdata = w_head_bypass ? mem_rdata : r_mdata[r_head];

  wb_load_align u_commit_align (
    .mdata      (w_commit_mdata),
    .rf_b       (w_head.rf_b),
    .addr       (w_head.alu_res[1:0]),
    .align_load (w_head.align_load),
    .data       (w_commit_load)
  );

  assign w_commit_data     = wb_select(w_head.src, w_head.alu_res, w_commit_load);
  assign rf_wen            = w_commit && w_head.wen;
  assign rf_waddr          = w_commit ? w_head.waddr : 5'd0;
  assign rf_wdata          = w_commit ? w_commit_data : 32'h0;
  assign debug_pc          = w_head_valid ? w_head.pc : 32'h0;
  assign debug_wb_rf_wen   = {RF_WEN_W{rf_wen}};
  assign debug_wb_rf_waddr = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign count             = r_count;
  assign resp_err          = r_resp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_filled   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every update sees pre-edge state.
      if (mem_rvalid) begin
        if (w_fill_found) r_filled[w_fill] <= 1'b1;
        else              r_resp_err       <= 1'b1;
      end
      // Placed after the fill update: a full queue can reuse the popping head slot.
      if (w_enq) begin
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_commit) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_commit);
    end
  end

  // NOTE: payload storage has no reset; validity is tracked by count and filled bits.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entry[r_tail] <= '{pc: in_pc, waddr: in_waddr, wen: in_wen, src: in_src,
                           alu_res: in_alu_res, rf_b: in_rf_b,
                           mem_read: in_mem_read, align_load: in_align_load};
    end
    if (mem_rvalid && w_fill_found) r_mdata[w_fill] <= mem_rdata;
  end

  // Forwarding: youngest live writer of the queried register wins.
  for (genvar p = 0; p < NRD; p++) begin : g_fwd
    logic [4:0]    w_raddr;
    logic          w_hit;
    logic [PW-1:0] w_sel;
    wb_entry_t     w_ent;
    logic [31:0]   w_load;

    assign w_raddr = fwd_raddr[5*p +: 5];

    always_comb begin
      w_hit = 1'b0;
      w_sel = r_head;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_live[i] && w_raddr != 5'd0 && r_entry[w_slot[i]].wen &&
            r_entry[w_slot[i]].waddr == w_raddr) begin
          w_hit = 1'b1;
          w_sel = w_slot[i];
        end
      end
    end

    assign w_ent = r_entry[w_sel];

    wb_load_align u_fwd_align (
      .mdata      (r_mdata[w_sel]),
      .rf_b       (w_ent.rf_b),
      .addr       (w_ent.alu_res[1:0]),
      .align_load (w_ent.align_load),
      .data       (w_load)
    );

    assign fwd_hit[p]           = w_hit;
    assign fwd_pending[p]       = w_hit && w_ent.mem_read && !r_filled[w_sel];
    assign fwd_data[32*p +: 32] = w_hit ? wb_select(w_ent.src, w_ent.alu_res, w_load) : 32'h0;
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a program-order reference model predicts commits,
// handshakes and forwarding; a negedge monitor compares against the DUT.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int NRD   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int K_LW = 6, K_LB = 5, K_LBU = 4, K_LH = 3, K_LHU = 2, K_LWL = 1, K_LWR = 0;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [31:0]       in_pc, in_alu_res, in_rf_b, mem_rdata;
  logic [4:0]        in_waddr;
  logic              in_wen, in_mem_read, mem_rvalid;
  logic [2:0]        in_src;
  logic [6:0]        in_align_load;
  logic              rf_wen;
  logic [4:0]        rf_waddr, debug_wb_rf_waddr;
  logic [31:0]       rf_wdata, debug_pc, debug_wb_rf_wdata;
  logic [3:0]        debug_wb_rf_wen;
  logic [5*NRD-1:0]  fwd_raddr;
  logic [NRD-1:0]    fwd_hit, fwd_pending;
  logic [32*NRD-1:0] fwd_data;
  logic [CW-1:0]     count;
  logic              resp_err;

  wb_queue #(.DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_wen(in_wen), .in_src(in_src),
    .in_alu_res(in_alu_res), .in_rf_b(in_rf_b), .in_mem_read(in_mem_read),
    .in_align_load(in_align_load), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_pc(debug_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_waddr(debug_wb_rf_waddr),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
    .fwd_pending(fwd_pending), .fwd_data(fwd_data), .count(count), .resp_err(resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        wen;
    logic [2:0]  src;
    logic [31:0] alu;
    logic [31:0] rfb;
    logic        mr;
    logic [6:0]  al;
  } instr_t;

  typedef struct { instr_t ins; int seq; } m_t;
  typedef struct { int cyc; logic [4:0] waddr; logic [31:0] data; } sb_t;

  // Reference model state
  m_t          prog_q[$];
  int          unf_q[$];
  sb_t         sb[$];
  logic [31:0] resp_data [int];
  int          seq_n, cyc;
  bit          m_err;
  logic [31:0] next_pc;
  logic [4:0]  qry [NRD];

  // Expectations for the current cycle, consumed by the monitor
  bit          pend_chk;
  int          exp_count;
  bit          exp_ready, exp_err, exp_pc_vld;
  logic [31:0] exp_pc;
  bit          exp_hit [NRD];
  bit          exp_pend [NRD];
  logic [31:0] exp_fdata [NRD];

  int n_cmp, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian MIPS load alignment, expressed with shifts and masks.
  function automatic logic [31:0] ref_align(input logic [31:0] m, input logic [31:0] b,
                                            input logic [1:0] a, input logic [6:0] al);
    int         ia;
    logic [7:0] by;
    logic [15:0] hf;
    ia = int'(a);
    by = 8'(m >> (8 * ia));
    hf = 16'(m >> (16 * (ia / 2)));
    if (al[K_LB])  return 32'($signed(by));
    if (al[K_LBU]) return {24'h0, by};
    if (al[K_LH])  return 32'($signed(hf));
    if (al[K_LHU]) return {16'h0, hf};
    if (al[K_LWL]) return (m << (8 * (3 - ia))) | (b & (32'hFFFF_FFFF >> (8 * (ia + 1))));
    if (al[K_LWR]) return (m >> (8 * ia)) | (b & ~(32'hFFFF_FFFF >> (8 * ia)));
    return m;
  endfunction

  function automatic logic [31:0] model_data(input m_t m);
    logic [31:0] md;
    md = resp_data.exists(m.seq) ? resp_data[m.seq] : 32'h0;
    if (m.ins.src[2]) return ref_align(md, m.ins.rfb, m.ins.alu[1:0], m.ins.al);
    return m.ins.alu;
  endfunction

  function automatic bit model_ready(input m_t m);
    return !m.ins.mr || resp_data.exists(m.seq);
  endfunction

  function automatic instr_t mk_alu(input logic [4:0] wa, input logic [31:0] val);
    instr_t t;
    t = '0;
    t.waddr = wa; t.wen = 1'b1; t.src = 3'b001; t.alu = val;
    return t;
  endfunction

  function automatic instr_t mk_load(input logic [4:0] wa, input int k,
                                     input logic [31:0] addr, input logic [31:0] rfb);
    instr_t t;
    t = '0;
    t.waddr = wa; t.wen = 1'b1; t.src = 3'b100; t.alu = addr;
    t.rfb = rfb; t.mr = 1'b1; t.al = 7'(1) << k;
    return t;
  endfunction

  // One clock of stimulus; the model predicts this cycle's outputs and state update.
  task automatic step(input bit v, input instr_t ins_in, input bit rv, input logic [31:0] rd);
    instr_t ins;
    bit     commit;
    m_t     m;
    @(posedge clk);
    #1;
    cyc++;
    ins = ins_in;
    ins.pc = next_pc;
    in_valid = v; in_pc = ins.pc; in_waddr = ins.waddr; in_wen = ins.wen;
    in_src = ins.src; in_alu_res = ins.alu; in_rf_b = ins.rfb;
    in_mem_read = ins.mr; in_align_load = ins.al;
    mem_rvalid = rv; mem_rdata = rd;
    for (int p = 0; p < NRD; p++) fwd_raddr[5*p +: 5] = qry[p];

    exp_count  = prog_q.size();
    exp_err    = m_err;
    exp_pc_vld = prog_q.size() > 0;
    exp_pc     = exp_pc_vld ? prog_q[0].ins.pc : 32'h0;
    for (int p = 0; p < NRD; p++) begin
      exp_hit[p] = 1'b0; exp_pend[p] = 1'b0; exp_fdata[p] = 32'h0;
      for (int i = 0; i < prog_q.size(); i++) begin
        if (qry[p] != 5'd0 && prog_q[i].ins.wen && prog_q[i].ins.waddr == qry[p]) begin
          exp_hit[p]   = 1'b1;
          exp_pend[p]  = !model_ready(prog_q[i]);
          exp_fdata[p] = model_data(prog_q[i]);
        end
      end
    end

    if (rv) begin
      if (unf_q.size() > 0) resp_data[unf_q.pop_front()] = rd;
      else m_err = 1'b1;
    end
    commit    = prog_q.size() > 0 && model_ready(prog_q[0]);
    exp_ready = prog_q.size() < DEPTH || commit;
    if (commit) begin
      m = prog_q.pop_front();
      if (m.ins.wen) sb.push_back('{cyc: cyc, waddr: m.ins.waddr, data: model_data(m)});
    end
    if (v && exp_ready) begin
      prog_q.push_back('{ins: ins, seq: seq_n});
      if (ins.mr) unf_q.push_back(seq_n);
      seq_n++;
      next_pc += 32'd4;
    end
    pend_chk = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_waddr = 0; in_wen = 0; in_src = 0; in_alu_res = 0;
    in_rf_b = 0; in_mem_read = 0; in_align_load = 0; mem_rvalid = 0; mem_rdata = 0;
    fwd_raddr = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && prog_q.size() > 0; k++)
      step(1'b0, '0, unf_q.size() > 0, $urandom);
    check("drain_bound", prog_q.size(), 0);
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin : monitor
    sb_t e;
    bit  ec;
    if (rst_n && pend_chk) begin
      pend_chk = 1'b0;
      check("in_ready", in_ready, exp_ready);
      check("count", count, exp_count);
      check("resp_err", resp_err, exp_err);
      if (exp_pc_vld) check("debug_pc", debug_pc, exp_pc);
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("fwd_hit%0d", p), fwd_hit[p], exp_hit[p]);
        check($sformatf("fwd_pending%0d", p), fwd_pending[p], exp_pend[p]);
        if (exp_hit[p] && !exp_pend[p])
          check($sformatf("fwd_data%0d", p), fwd_data[32*p +: 32], exp_fdata[p]);
      end
      ec = sb.size() > 0 && sb[0].cyc == cyc;
      check("rf_wen", rf_wen, ec);
      check("debug_wb_rf_wen", debug_wb_rf_wen, {4{ec}});
      if (ec) begin
        e = sb.pop_front();
        check("rf_waddr", rf_waddr, e.waddr);
        check("rf_wdata", rf_wdata, e.data);
        check("debug_wb_rf_waddr", debug_wb_rf_waddr, e.waddr);
        check("debug_wb_rf_wdata", debug_wb_rf_wdata, e.data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    instr_t t;
    n_cmp = 0; n_bad = 0; seq_n = 0; cyc = 0; m_err = 0; pend_chk = 0;
    next_pc = 32'h0040_0000;
    for (int p = 0; p < NRD; p++) qry[p] = 5'd0;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_debug_pc", debug_pc, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU back-to-back
    step(1, mk_alu(5'd3, 32'h11), 0, 0);
    step(1, mk_alu(5'd4, 32'h22), 0, 0);
    @(negedge clk);
    check("alu1_wdata", rf_wdata, 32'h11);
    check("alu1_count", count, 1);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("alu2_wdata", rf_wdata, 32'h22);
    check("alu2_count", count, 1);

    // lb with same-cycle response bypass
    step(1, mk_load(5'd6, K_LB, 32'h0000_1002, 32'h0), 0, 0);
    step(0, '0, 1, 32'h00F6_0000);
    @(negedge clk);
    check("lb_wdata", rf_wdata, 32'hFFFF_FFF6);
    check("lb_dbg_wen", debug_wb_rf_wen, 4'hF);

    // lwl / lwr merges
    step(1, mk_load(5'd7, K_LWL, 32'h0000_2001, 32'hAABB_CCDD), 0, 0);
    step(1, mk_load(5'd8, K_LWR, 32'h0000_2002, 32'hAABB_CCDD), 0, 0);
    step(0, '0, 1, 32'h1122_3344);
    @(negedge clk);
    check("lwl_wdata", rf_wdata, 32'h3344_CCDD);
    step(0, '0, 1, 32'h1122_3344);
    @(negedge clk);
    check("lwr_wdata", rf_wdata, 32'hAABB_1122);

    // Full queue: four stalled loads, then commit and enqueue in one cycle
    for (int i = 0; i < DEPTH; i++) step(1, mk_load(5'(10 + i), K_LW, 32'h3000 + 4 * i, 0), 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, DEPTH);
    step(1, mk_alu(5'd20, 32'h55), 1, 32'hDEAD_0001);
    @(negedge clk);
    check("full_commit_ready", in_ready, 1);
    check("full_commit_wen", rf_wen, 1);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("full_count_kept", count, DEPTH);
    drain();

    // Forwarding from ALU then an unfilled load to the same register
    qry[0] = 5'd5; qry[1] = 5'd0;
    step(1, mk_load(5'd9, K_LW, 32'h4000, 0), 0, 0);
    step(1, mk_alu(5'd5, 32'h7), 0, 0);
    step(1, mk_load(5'd5, K_LW, 32'h4004, 0), 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("fwd5_hit", fwd_hit[0], 1);
    check("fwd5_pending", fwd_pending[0], 1);
    check("fwd0_hit", fwd_hit[1], 0);
    step(0, '0, 1, 32'h1234_5678);
    step(0, '0, 1, 32'hCAFE_F00D);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("fwd5_filled_pending", fwd_pending[0], 0);
    check("fwd5_data", fwd_data[31:0], 32'hCAFE_F00D);
    drain();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < NRD; p++) qry[p] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        t = mk_alu(5'($urandom_range(0, 7)), $urandom);
        t.src = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
      end else begin
        t = mk_load(5'($urandom_range(0, 7)), $urandom_range(0, 6), $urandom, $urandom);
      end
      t.wen = $urandom_range(0, 7) != 0;
      step($urandom_range(0, 3) != 0, t, unf_q.size() > 0 && $urandom_range(0, 1) == 0, $urandom);
    end
    drain();

    // Stray response on an empty queue
    step(0, '0, 1, 32'hBAD0_BAD0);
    step(0, '0, 0, 0);
    @(negedge clk);
    check("stray_resp_err", resp_err, 1);
    check("stray_count", count, 0);

    // Asynchronous reset with entries queued
    step(1, mk_load(5'd1, K_LW, 32'h5000, 0), 0, 0);
    step(1, mk_load(5'd2, K_LW, 32'h5004, 0), 0, 0);
    step(1, mk_alu(5'd3, 32'h33), 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_resp_err", resp_err, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_debug_pc", debug_pc, 0);
    prog_q.delete(); unf_q.delete(); sb.delete();
    m_err = 1'b0; pend_chk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, mk_alu(5'd12, 32'h77), 0, 0);
    step(0, '0, 0, 0);
    drain();
    @(negedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
